// File: rtl/tff_pkg.sv
// Shared definitions for the tff_bank register bank.
// Holds the mode encodings and the 2-bit mode type used by the bank
// and by its single-bit next-state cell.
package tff_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_T   = 2'b00;
  localparam mode_t MODE_D   = 2'b01;
  localparam mode_t MODE_JK  = 2'b10;
  localparam mode_t MODE_CNT = 2'b11;

endpackage

// File: rtl/tff_cell.sv
// Single-bit next-state function for one channel of tff_bank.
// Purely combinational; the bank owns all registers.
// Ports:
//   mode      - register type selected for this edge
//   q         - current registered state of this channel
//   t, d      - toggle request / load data
//   j, k      - JK inputs
//   carry_in  - high when every lower channel is 1 (bit 0 is fed 1)
//   q_n       - next state of this channel
//   carry_out - carry_in & q, feeds the next channel up
module tff_cell
  import tff_pkg::*;
(
  input  mode_t mode,
  input  logic  q,
  input  logic  t,
  input  logic  d,
  input  logic  j,
  input  logic  k,
  input  logic  carry_in,
  output logic  q_n,
  output logic  carry_out
);

  always_comb begin
    q_n = q;
    case (mode)
      MODE_T:   q_n = q ^ t;
      MODE_D:   q_n = d;
      MODE_JK: begin
        case ({j, k})
          2'b00:   q_n = q;
          2'b01:   q_n = 1'b0;
          2'b10:   q_n = 1'b1;
          default: q_n = ~q;
        endcase
      end
      // Counting is a toggle enabled by all lower bits being set.
      default:  q_n = q ^ carry_in;
    endcase
  end

  assign carry_out = carry_in & q;

endmodule

// File: rtl/tff_bank.sv
// Bank of WIDTH flip-flop channels sharing one enable and one mode.
// Each enabled edge the bank acts as T, D, JK or a binary counter,
// reports the bits that changed, counts (saturating) the edges on
// which anything changed, and flags the all-ones to zero wrap in
// counter mode.
// Ports:
//   clk, rst  - rising-edge clock, synchronous active-high reset
//   en        - global enable; low holds q/qbar/tog_cnt
//   mode      - 00=T, 01=D, 10=JK, 11=CNT
//   t,d,j,k   - per-bit inputs for the respective modes
//   q, qbar   - registered state and its complement
//   tog_mask  - bits of q that changed on the last edge
//   tog_cnt   - saturating count of edges on which q changed
//   cnt_wrap  - one-cycle pulse after an all-ones to zero count
module tff_bank
  import tff_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               CNT_W     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] tog_mask,
  output logic [CNT_W-1:0] tog_cnt,
  output logic             cnt_wrap
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  mode_t            mode_s;
  logic [WIDTH-1:0] q_n;
  logic [WIDTH:0]   carry;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] qbar_q, qbar_d;
  logic [WIDTH-1:0] tog_mask_q, tog_mask_d;
  logic [CNT_W-1:0] tog_cnt_q, tog_cnt_d;
  logic             cnt_wrap_q, cnt_wrap_d;

  assign mode_s   = mode_t'(mode);
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .mode      (mode_s),
      .q         (q_q[i]),
      .t         (t[i]),
      .d         (d[i]),
      .j         (j[i]),
      .k         (k[i]),
      .carry_in  (carry[i]),
      .q_n       (q_n[i]),
      .carry_out (carry[i+1])
    );
  end

  always_comb begin
    q_d        = q_q;
    qbar_d     = qbar_q;
    tog_mask_d = '0;
    tog_cnt_d  = tog_cnt_q;
    cnt_wrap_d = 1'b0;
    if (rst) begin
      q_d       = RESET_VAL;
      qbar_d    = ~RESET_VAL;
      tog_cnt_d = '0;
    end else if (en) begin
      q_d        = q_n;
      qbar_d     = ~q_n;
      tog_mask_d = q_q ^ q_n;
      if ((q_n != q_q) && (tog_cnt_q != CNT_MAX)) begin
        tog_cnt_d = tog_cnt_q + 1'b1;
      end
      // The top carry is &q, i.e. the counter is about to roll over.
      cnt_wrap_d = (mode_s == MODE_CNT) && carry[WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    q_q        <= q_d;
    qbar_q     <= qbar_d;
    tog_mask_q <= tog_mask_d;
    tog_cnt_q  <= tog_cnt_d;
    cnt_wrap_q <= cnt_wrap_d;
  end

  assign q        = q_q;
  assign qbar     = qbar_q;
  assign tog_mask = tog_mask_q;
  assign tog_cnt  = tog_cnt_q;
  assign cnt_wrap = cnt_wrap_q;

endmodule

// File: tb/tb_tff_bank.sv
module tb_tff_bank;

  localparam logic [1:0] M_T   = 2'b00;
  localparam logic [1:0] M_D   = 2'b01;
  localparam logic [1:0] M_JK  = 2'b10;
  localparam logic [1:0] M_CNT = 2'b11;

  logic       clk;
  logic       rst, en;
  logic [1:0] mode;
  logic [7:0] t, d, j, k;

  int errors = 0;
  int checks = 0;

  // dut8: WIDTH 8, CNT_W 16, RESET_VAL A5
  logic [7:0]  q8, qb8, m8;
  logic [15:0] c8;
  logic        w8;
  // dutS: WIDTH 8, CNT_W 2, RESET_VAL 00
  logic [7:0]  qS, qbS, mS;
  logic [1:0]  cS;
  logic        wS;
  // dut4: WIDTH 4, CNT_W 4, RESET_VAL 3
  logic [3:0]  q4, qb4, m4, c4;
  logic        w4;
  // dut1: WIDTH 1, CNT_W 4, RESET_VAL 0
  logic [0:0]  q1, qb1, m1;
  logic [3:0]  c1;
  logic        w1;

  tff_bank #(.WIDTH(8), .CNT_W(16), .RESET_VAL(8'hA5)) dut8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .d(d), .j(j), .k(k),
    .q(q8), .qbar(qb8), .tog_mask(m8), .tog_cnt(c8), .cnt_wrap(w8));

  tff_bank #(.WIDTH(8), .CNT_W(2), .RESET_VAL(8'h00)) dutS (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .d(d), .j(j), .k(k),
    .q(qS), .qbar(qbS), .tog_mask(mS), .tog_cnt(cS), .cnt_wrap(wS));

  tff_bank #(.WIDTH(4), .CNT_W(4), .RESET_VAL(4'h3)) dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t[3:0]), .d(d[3:0]),
    .j(j[3:0]), .k(k[3:0]),
    .q(q4), .qbar(qb4), .tog_mask(m4), .tog_cnt(c4), .cnt_wrap(w4));

  tff_bank #(.WIDTH(1), .CNT_W(4), .RESET_VAL(1'b0)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t[0:0]), .d(d[0:0]),
    .j(j[0:0]), .k(k[0:0]),
    .q(q1), .qbar(qb1), .tog_mask(m1), .tog_cnt(c1), .cnt_wrap(w1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one entry per DUT instance
  int         mw[4]   = '{8, 8, 4, 1};
  int         mcmax[4] = '{65535, 3, 15, 15};
  logic [7:0] mrv[4]  = '{8'hA5, 8'h00, 8'h03, 8'h00};
  logic [7:0] mq[4];
  logic [7:0] mmask[4];
  int         mcnt[4];
  logic       mwrap[4];

  // Observed outputs gathered per instance, zero-extended
  logic [7:0] aq[4], aqb[4], am[4];
  int         ac[4];
  logic       aw[4];

  always_comb begin
    aq[0] = q8;          aqb[0] = qb8;          am[0] = m8;
    aq[1] = qS;          aqb[1] = qbS;          am[1] = mS;
    aq[2] = {4'b0, q4};  aqb[2] = {4'b0, qb4};  am[2] = {4'b0, m4};
    aq[3] = {7'b0, q1};  aqb[3] = {7'b0, qb1};  am[3] = {7'b0, m1};
    ac[0] = {16'b0, c8}; ac[1] = {30'b0, cS};
    ac[2] = {28'b0, c4}; ac[3] = {28'b0, c1};
    aw[0] = w8; aw[1] = wS; aw[2] = w4; aw[3] = w1;
  end

  function automatic logic [7:0] wmask(input int w);
    return 8'((1 << w) - 1);
  endfunction

  function automatic logic [7:0] next_q(input logic [7:0] cur, input int w,
                                        input logic [1:0] m, input logic [7:0] tt,
                                        input logic [7:0] dd, input logic [7:0] jj,
                                        input logic [7:0] kk);
    logic [7:0] n;
    n = cur;
    case (m)
      M_T: n = cur ^ tt;
      M_D: n = dd;
      M_JK: begin
        for (int b = 0; b < 8; b++) begin
          if (jj[b] && kk[b])      n[b] = ~cur[b];
          else if (jj[b])          n[b] = 1'b1;
          else if (kk[b])          n[b] = 1'b0;
        end
      end
      default: n = cur + 8'd1;
    endcase
    return n & wmask(w);
  endfunction

  function automatic void model_update(input int i);
    logic [7:0] n;
    if (rst) begin
      mq[i] = mrv[i]; mmask[i] = 8'h00; mcnt[i] = 0; mwrap[i] = 1'b0;
    end else if (!en) begin
      mmask[i] = 8'h00; mwrap[i] = 1'b0;
    end else begin
      n = next_q(mq[i], mw[i], mode, t, d, j, k);
      mwrap[i] = (mode == M_CNT) && (mq[i] == wmask(mw[i]));
      mmask[i] = mq[i] ^ n;
      if (n != mq[i] && mcnt[i] < mcmax[i]) mcnt[i] = mcnt[i] + 1;
      mq[i] = n;
    end
  endfunction

  task automatic step(input logic r, input logic e, input logic [1:0] m,
                      input logic [7:0] tt, input logic [7:0] dd,
                      input logic [7:0] jj, input logic [7:0] kk);
    rst = r; en = e; mode = m; t = tt; d = dd; j = jj; k = kk;
    @(posedge clk);
    for (int i = 0; i < 4; i++) model_update(i);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, M_T, 8'hFF, 8'h00, 8'h00, 8'h00);
    step(1'b1, 1'b1, M_T, 8'hFF, 8'h00, 8'h00, 8'h00);
    checks++; if (q8 !== 8'hA5) begin errors++; $display("FAIL reset_q got=%h exp=a5", q8); end
    checks++; if (qb8 !== 8'h5A) begin errors++; $display("FAIL reset_qbar got=%h exp=5a", qb8); end
    checks++; if (m8 !== 8'h00) begin errors++; $display("FAIL reset_mask got=%h exp=00", m8); end
    checks++; if (c8 !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", c8); end
    checks++; if (w8 !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b exp=0", w8); end
  endtask

  task automatic test_t_mode();
    step(1'b0, 1'b1, M_T, 8'h0F, 8'h00, 8'h00, 8'h00);
    checks++; if (qS !== 8'h0F) begin errors++; $display("FAIL t_edge1_q got=%h exp=0f", qS); end
    checks++; if (mS !== 8'h0F) begin errors++; $display("FAIL t_edge1_mask got=%h exp=0f", mS); end
    step(1'b0, 1'b1, M_T, 8'h0F, 8'h00, 8'h00, 8'h00);
    checks++; if (qS !== 8'h00) begin errors++; $display("FAIL t_edge2_q got=%h exp=00", qS); end
    checks++; if (cS !== 2'd2) begin errors++; $display("FAIL t_edge2_cnt got=%0d exp=2", cS); end
    for (int n = 0; n < 3; n++) begin
      step(1'b0, 1'b0, M_D, 8'hFF, 8'hFF, 8'hFF, 8'h00);
      checks++; if (qS !== 8'h00) begin errors++; $display("FAIL hold_q[%0d] got=%h exp=00", n, qS); end
      checks++; if (mS !== 8'h00) begin errors++; $display("FAIL hold_mask[%0d] got=%h exp=00", n, mS); end
      checks++; if (cS !== 2'd2) begin errors++; $display("FAIL hold_cnt[%0d] got=%0d exp=2", n, cS); end
    end
  endtask

  task automatic test_jk();
    step(1'b0, 1'b1, M_D, 8'h00, 8'hF0, 8'h00, 8'h00);
    checks++; if (q8 !== 8'hF0) begin errors++; $display("FAIL jk_load got=%h exp=f0", q8); end
    // per bit: 7,3 toggle; 6,2 set; 5,1 clear; 4,0 hold
    step(1'b0, 1'b1, M_JK, 8'h00, 8'h00, 8'hCC, 8'hAA);
    checks++; if (q8 !== 8'h5C) begin errors++; $display("FAIL jk_q got=%h exp=5c", q8); end
    checks++; if (m8 !== 8'hAC) begin errors++; $display("FAIL jk_mask got=%h exp=ac", m8); end
    checks++; if (qb8 !== 8'hA3) begin errors++; $display("FAIL jk_qbar got=%h exp=a3", qb8); end
  endtask

  task automatic test_cnt_wrap();
    logic [3:0] exp4[3] = '{4'hF, 4'h0, 4'h1};
    logic       expw[3] = '{1'b0, 1'b1, 1'b0};
    logic       exp1[3] = '{1'b1, 1'b0, 1'b1};
    step(1'b0, 1'b1, M_D, 8'h00, 8'h0E, 8'h00, 8'h00);
    checks++; if (q4 !== 4'hE) begin errors++; $display("FAIL cnt_load got=%h exp=e", q4); end
    for (int n = 0; n < 3; n++) begin
      step(1'b0, 1'b1, M_CNT, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
      checks++; if (q4 !== exp4[n]) begin errors++; $display("FAIL cnt_q[%0d] got=%h exp=%h", n, q4, exp4[n]); end
      checks++; if (w4 !== expw[n]) begin errors++; $display("FAIL cnt_wrap[%0d] got=%b exp=%b", n, w4, expw[n]); end
      checks++; if (q1 !== exp1[n]) begin errors++; $display("FAIL w1_q[%0d] got=%b exp=%b", n, q1, exp1[n]); end
      checks++; if (w1 !== expw[n]) begin errors++; $display("FAIL w1_wrap[%0d] got=%b exp=%b", n, w1, expw[n]); end
    end
  endtask

  task automatic test_saturation();
    int expc[5] = '{1, 2, 3, 3, 3};
    step(1'b1, 1'b0, M_T, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int n = 0; n < 5; n++) begin
      step(1'b0, 1'b1, M_T, 8'h01, 8'h00, 8'h00, 8'h00);
      checks++;
      if ({30'b0, cS} !== expc[n]) begin
        errors++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", n, cS, expc[n]);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b1, M_D, 8'h00, 8'h0F, 8'h00, 8'h00);
    checks++; if (q4 !== 4'hF) begin errors++; $display("FAIL rmid_load got=%h exp=f", q4); end
    step(1'b1, 1'b1, M_CNT, 8'h00, 8'h00, 8'h00, 8'h00);
    checks++; if (q4 !== 4'h3) begin errors++; $display("FAIL rmid_q got=%h exp=3", q4); end
    checks++; if (w4 !== 1'b0) begin errors++; $display("FAIL rmid_wrap got=%b exp=0", w4); end
    checks++; if (c4 !== 4'd0) begin errors++; $display("FAIL rmid_cnt got=%0d exp=0", c4); end
    step(1'b0, 1'b0, M_CNT, 8'h00, 8'h00, 8'h00, 8'h00);
    checks++; if (w4 !== 1'b0) begin errors++; $display("FAIL rmid_wrap_after got=%b exp=0", w4); end
  endtask

  task automatic test_random();
    logic       r, e;
    logic [1:0] m;
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 23) == 0);
      e = ($urandom_range(0, 3) != 0);
      m = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) m = M_CNT;
      step(r, e, m, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (aq[i] !== mq[i]) begin
          errors++; $display("FAIL rnd_q dut%0d cyc%0d got=%h exp=%h", i, n, aq[i], mq[i]);
        end
        checks++;
        if (aqb[i] !== (~mq[i] & wmask(mw[i]))) begin
          errors++; $display("FAIL rnd_qbar dut%0d cyc%0d got=%h exp=%h", i, n, aqb[i], ~mq[i] & wmask(mw[i]));
        end
        checks++;
        if (am[i] !== mmask[i]) begin
          errors++; $display("FAIL rnd_mask dut%0d cyc%0d got=%h exp=%h", i, n, am[i], mmask[i]);
        end
        checks++;
        if (ac[i] !== mcnt[i]) begin
          errors++; $display("FAIL rnd_cnt dut%0d cyc%0d got=%0d exp=%0d", i, n, ac[i], mcnt[i]);
        end
        checks++;
        if (aw[i] !== mwrap[i]) begin
          errors++; $display("FAIL rnd_wrap dut%0d cyc%0d got=%b exp=%b", i, n, aw[i], mwrap[i]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = M_T; t = '0; d = '0; j = '0; k = '0;
    test_reset();
    test_t_mode();
    test_jk();
    test_cnt_wrap();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
